// File: rtl/load_store_unit.sv
// Load/store unit: turns an RV32I load/store into one valid/ready transaction on the
// data-memory port, stalls the core while it runs and returns extended load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ErrOk       = 2'b00;
    localparam logic [1:0] ErrMisalign = 2'b01;
    localparam logic [1:0] ErrTimeout  = 2'b10;
    localparam logic [1:0] ErrIllegal  = 2'b11;

    typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_t;

    state_t          state_q, state_d;
    logic [1:0]      err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Transaction fields captured when the access is accepted
    logic            we_q;
    logic [2:0]      f3_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;

    logic            illegal;
    logic            misaligned;
    logic [3:0]      be_new;
    logic [31:0]     wdata_new;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     load_ext;

    // Decode the incoming access: legality, alignment, byte enables, lane-replicated data
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_new     = 4'b0000;
        wdata_new  = store_data;
        if (is_store) begin
            illegal = funct3[2] | (funct3 == 3'b011);
        end else begin
            illegal = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
        end
        misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                     ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        unique case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << addr[1:0];
                wdata_new = {2{store_data[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = store_data;
            end
        endcase
    end

    // Next-state logic, error latching and timeout counting
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (illegal) begin
                        err_d   = ErrIllegal;
                        state_d = StErr;
                    end else if (misaligned) begin
                        err_d   = ErrMisalign;
                        state_d = StErr;
                    end else begin
                        err_d   = ErrOk;
                        cnt_d   = '0;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_q + CntW'(1);
                if (mem_ready) begin
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    err_d   = ErrTimeout;
                    state_d = StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, error code and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            err_q   <= ErrOk;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request fields so they stay stable while the memory stalls
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
        end else if ((state_q == StIdle) && start) begin
            we_q    <= is_store;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata_new;
            be_q    <= be_new;
        end
    end

    // Lane extraction and sign/zero extension of the returned word
    always_comb begin
        lane_b   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        load_ext = mem_rdata;
        unique case (f3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'h000000, lane_b};
            3'b101:  load_ext = {16'h0000, lane_h};
            default: load_ext = mem_rdata;
        endcase
    end

    // Load result register; only a completed load updates it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_data <= '0;
        end else if ((state_q == StReq) && mem_ready && !we_q) begin
            load_data <= load_ext;
        end
    end

    // Core- and memory-facing outputs; memory fields are zero outside REQ
    always_comb begin
        mem_req   = (state_q == StReq);
        mem_we    = mem_req & we_q;
        mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_wdata = mem_req ? wdata_q : 32'h0;
        mem_be    = mem_req ? be_q : 4'b0000;
        busy      = ((state_q == StIdle) & start) | mem_req;
        done      = (state_q == StDone) | (state_q == StErr);
        err_code  = (state_q == StErr) ? err_q : ErrOk;
    end

endmodule
